// File: rtl/ms6205_pkg.sv
// Shared types and constants for the MS6205 panel responder.
// Holds the sequencer FSM state type, the panel geometry defaults and the character/address widths.
package ms6205_pkg;

    localparam int DEPTH_DEF = 160;
    localparam int COLS_DEF  = 16;
    localparam int ROWS_DEF  = DEPTH_DEF / COLS_DEF;
    localparam int CHAR_W    = 8;
    localparam int ADDR_W    = 8;

    typedef enum logic [1:0] {
        IDLE,
        PEND_ADDR,
        PEND_DATA
    } state_e;

    // Cursor advance with wrap from the last cell back to cell 0.
    function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] a, input int depth);
        return (int'(a) == depth - 1) ? '0 : a + 1'b1;
    endfunction

endpackage

// File: rtl/strobe_edge.sv
// Falling-edge event detector for an active-low sequencer strobe; a held-low strobe yields one event.
// Latency: event is combinational from the current sample; no backpressure.
module strobe_edge (
    input  logic Clock_1us,
    input  logic Rst_n,
    input  logic strobe_n,
    output logic fire
);

    logic prev_q;
    logic prev_d;

    always_comb begin
        prev_d = strobe_n;
    end

    always_ff @(posedge Clock_1us or negedge Rst_n) begin
        if (!Rst_n) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign fire = prev_q & ~strobe_n;

endmodule

// File: rtl/ms6205_responder.sv
// MS6205 panel responder: holds one host character update and hands it to the panel sequencer via acq/strobe handshake.
// Latency: host_ready drops the cycle after accept; rd_data 1 cycle. Host is held off until the data strobe lands.
// Optional MS6205_AUTOINC_EN: skip the address write when the target already equals the cursor.
module ms6205_responder
    import ms6205_pkg::*;
#(
    parameter int COLS = COLS_DEF,
    parameter int ROWS = ROWS_DEF
) (
    input  logic              Clock_1us,
    input  logic              Rst_n,
    input  logic              host_valid,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [CHAR_W-1:0] host_data,
    output logic              host_ready,
    output logic              ms6205_addr_acq,
    output logic              ms6205_data_acq,
    input  logic              ms6205_write_addr_n,
    input  logic              ms6205_write_data_n,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [CHAR_W-1:0] rd_data,
    output logic [ADDR_W-1:0] cursor,
    output logic              proto_err
);

    localparam int DEPTH = COLS * ROWS;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cursor_q, cursor_d;
    logic [ADDR_W-1:0] hold_addr_q, hold_addr_d;
    logic [CHAR_W-1:0] hold_data_q, hold_data_d;
    logic              host_ready_q, host_ready_d;
    logic              addr_acq_q, addr_acq_d;
    logic              data_acq_q, data_acq_d;
    logic              proto_err_q, proto_err_d;
    logic [CHAR_W-1:0] rd_data_q, rd_data_d;

    logic [CHAR_W-1:0] mem [DEPTH];
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;

    logic              addr_ev;
    logic              data_ev;
    logic              accept;
    logic              addr_oor;
    logic [ADDR_W-1:0] host_addr_eff;
    logic              need_addr;

    strobe_edge u_addr_edge (
        .Clock_1us (Clock_1us),
        .Rst_n     (Rst_n),
        .strobe_n  (ms6205_write_addr_n),
        .fire      (addr_ev)
    );

    strobe_edge u_data_edge (
        .Clock_1us (Clock_1us),
        .Rst_n     (Rst_n),
        .strobe_n  (ms6205_write_data_n),
        .fire      (data_ev)
    );

    always_comb begin
        accept        = host_valid & host_ready_q & (state_q == IDLE);
        addr_oor      = int'(host_addr) >= DEPTH;
        host_addr_eff = addr_oor ? '0 : host_addr;
`ifdef MS6205_AUTOINC_EN
        need_addr     = (host_addr_eff != cursor_q);
`else
        need_addr     = 1'b1;
`endif
    end

    always_comb begin
        state_d     = state_q;
        cursor_d    = cursor_q;
        hold_addr_d = hold_addr_q;
        hold_data_d = hold_data_q;
        proto_err_d = proto_err_q;
        mem_we      = 1'b0;
        mem_waddr   = cursor_q;

        case (state_q)
            IDLE: begin
                if (addr_ev || data_ev) begin
                    proto_err_d = 1'b1;
                end
                if (accept) begin
                    hold_addr_d = host_addr_eff;
                    hold_data_d = host_data;
                    if (addr_oor) begin
                        proto_err_d = 1'b1;
                    end
                    state_d = need_addr ? PEND_ADDR : PEND_DATA;
                end
            end
            PEND_ADDR: begin
                if (addr_ev) begin
                    cursor_d = hold_addr_q;
                    if (data_ev) begin
                        // Same-cycle strobes: the address lands first, then the write uses it.
                        mem_we    = 1'b1;
                        mem_waddr = hold_addr_q;
                        cursor_d  = wrap_inc(hold_addr_q, DEPTH);
                        state_d   = IDLE;
                    end else begin
                        state_d = PEND_DATA;
                    end
                end else if (data_ev) begin
                    proto_err_d = 1'b1;
                end
            end
            PEND_DATA: begin
                if (addr_ev) begin
                    cursor_d = hold_addr_q;
                end
                if (data_ev) begin
                    mem_we    = 1'b1;
                    mem_waddr = addr_ev ? hold_addr_q : cursor_q;
                    cursor_d  = wrap_inc(mem_waddr, DEPTH);
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        host_ready_d = (state_d == IDLE);
        addr_acq_d   = (state_d == PEND_ADDR);
        data_acq_d   = (state_d != IDLE);
        rd_data_d    = (int'(rd_addr) < DEPTH) ? mem[rd_addr] : '0;
    end

    always_ff @(posedge Clock_1us or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q      <= IDLE;
            cursor_q     <= '0;
            hold_addr_q  <= '0;
            hold_data_q  <= '0;
            host_ready_q <= 1'b1;
            addr_acq_q   <= 1'b0;
            data_acq_q   <= 1'b0;
            proto_err_q  <= 1'b0;
            rd_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            cursor_q     <= cursor_d;
            hold_addr_q  <= hold_addr_d;
            hold_data_q  <= hold_data_d;
            host_ready_q <= host_ready_d;
            addr_acq_q   <= addr_acq_d;
            data_acq_q   <= data_acq_d;
            proto_err_q  <= proto_err_d;
            rd_data_q    <= rd_data_d;
        end
    end

    // Character RAM is deliberately outside the reset domain: panel contents survive reset.
    always_ff @(posedge Clock_1us) begin
        if (mem_we) begin
            mem[mem_waddr] <= hold_data_q;
        end
    end

    assign host_ready      = host_ready_q;
    assign ms6205_addr_acq = addr_acq_q;
    assign ms6205_data_acq = data_acq_q;
    assign rd_data         = rd_data_q;
    assign cursor          = cursor_q;
    assign proto_err       = proto_err_q;

endmodule

// File: tb/tb_ms6205_responder.sv
// Self-checking bench for ms6205_responder: table vectors, hand-written corner sequences, randomized transactions vs a reference model.
module tb_ms6205_responder;

    localparam int DEPTH = 160;

    logic       Clock_1us = 1'b0;
    logic       Rst_n;
    logic       host_valid;
    logic [7:0] host_addr;
    logic [7:0] host_data;
    logic       host_ready;
    logic       ms6205_addr_acq;
    logic       ms6205_data_acq;
    logic       ms6205_write_addr_n;
    logic       ms6205_write_data_n;
    logic [7:0] rd_addr;
    logic [7:0] rd_data;
    logic [7:0] cursor;
    logic       proto_err;

    ms6205_responder #(.COLS(16), .ROWS(10)) dut (
        .Clock_1us           (Clock_1us),
        .Rst_n               (Rst_n),
        .host_valid          (host_valid),
        .host_addr           (host_addr),
        .host_data           (host_data),
        .host_ready          (host_ready),
        .ms6205_addr_acq     (ms6205_addr_acq),
        .ms6205_data_acq     (ms6205_data_acq),
        .ms6205_write_addr_n (ms6205_write_addr_n),
        .ms6205_write_data_n (ms6205_write_data_n),
        .rd_addr             (rd_addr),
        .rd_data             (rd_data),
        .cursor              (cursor),
        .proto_err           (proto_err)
    );

    always #5 Clock_1us = ~Clock_1us;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    // Reference model: panel contents, cursor and sticky error at transaction level.
    int mem_m [DEPTH];
    int cursor_m;
    bit proto_m;

    typedef struct {
        int addr;
        int data;
        bit both;
        int exp_cell;
        int exp_cursor;
        bit exp_proto;
    } vec_t;

    task automatic check(input string nm, input int act, input int exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: actual %0d required %0d", nm, act, exp);
    endtask

    task automatic host_put(input int a, input int d);
        host_valid = 1'b1;
        host_addr  = 8'(a);
        host_data  = 8'(d);
        @(negedge Clock_1us);
        host_valid = 1'b0;
    endtask

    task automatic pulse(input bit do_addr, input bit do_data);
        ms6205_write_addr_n = ~do_addr;
        ms6205_write_data_n = ~do_data;
        @(negedge Clock_1us);
        ms6205_write_addr_n = 1'b1;
        ms6205_write_data_n = 1'b1;
    endtask

    task automatic read_cell(input int a, output int v);
        rd_addr = 8'(a);
        @(negedge Clock_1us);
        v = int'(rd_data);
    endtask

    task automatic do_reset();
        Rst_n = 1'b0;
        @(negedge Clock_1us);
        Rst_n = 1'b1;
        @(negedge Clock_1us);
        cursor_m = 0;
        proto_m  = 1'b0;
    endtask

    function automatic bit model_need_addr(input int ea);
`ifdef MS6205_AUTOINC_EN
        return ea != cursor_m;
`else
        return 1'b1;
`endif
    endfunction

    // One complete host update driven through the sequencer handshake, checked at each phase.
    task automatic txn(input int a, input int d, input bit both);
        int ea;
        bit need;
        int v;
        ea   = (a >= DEPTH) ? 0 : a;
        need = model_need_addr(ea);
        check("ready_before", int'(host_ready), 1);
        host_put(a, d);
        check("addr_acq_pend", int'(ms6205_addr_acq), int'(need));
        check("data_acq_pend", int'(ms6205_data_acq), 1);
        check("ready_busy", int'(host_ready), 0);
        if (both && need) begin
            pulse(1'b1, 1'b1);
        end else begin
            if (need) begin
                pulse(1'b1, 1'b0);
                check("addr_acq_after_addr", int'(ms6205_addr_acq), 0);
                check("cursor_after_addr", int'(cursor), ea);
            end
            pulse(1'b0, 1'b1);
        end
        mem_m[ea] = d;
        cursor_m  = (ea + 1) % DEPTH;
        if (a >= DEPTH) proto_m = 1'b1;
        check("cursor_done", int'(cursor), cursor_m);
        check("ready_done", int'(host_ready), 1);
        check("addr_acq_done", int'(ms6205_addr_acq), 0);
        check("data_acq_done", int'(ms6205_data_acq), 0);
        check("proto_done", int'(proto_err), int'(proto_m));
        read_cell(ea, v);
        check("mem_written", v, d);
    endtask

    initial begin
        vec_t vecs [5];
        int v;
        int a;
        int d;

        vecs[0] = '{addr: 5,   data: 'h41, both: 1'b0, exp_cell: 5,   exp_cursor: 6,  exp_proto: 1'b0};
        vecs[1] = '{addr: 6,   data: 'h42, both: 1'b0, exp_cell: 6,   exp_cursor: 7,  exp_proto: 1'b0};
        vecs[2] = '{addr: 159, data: 'h7e, both: 1'b0, exp_cell: 159, exp_cursor: 0,  exp_proto: 1'b0};
        vecs[3] = '{addr: 20,  data: 'h33, both: 1'b1, exp_cell: 20,  exp_cursor: 21, exp_proto: 1'b0};
        vecs[4] = '{addr: 200, data: 'h55, both: 1'b0, exp_cell: 0,   exp_cursor: 1,  exp_proto: 1'b1};

        for (int i = 0; i < DEPTH; i++) mem_m[i] = -1;
        Rst_n               = 1'b0;
        host_valid          = 1'b0;
        host_addr           = '0;
        host_data           = '0;
        ms6205_write_addr_n = 1'b1;
        ms6205_write_data_n = 1'b1;
        rd_addr             = '0;
        cursor_m            = 0;
        proto_m             = 1'b0;
        repeat (3) @(negedge Clock_1us);

        check("rst_ready", int'(host_ready), 1);
        check("rst_addr_acq", int'(ms6205_addr_acq), 0);
        check("rst_data_acq", int'(ms6205_data_acq), 0);
        check("rst_cursor", int'(cursor), 0);
        check("rst_proto", int'(proto_err), 0);
        check("rst_rd_data", int'(rd_data), 0);
        Rst_n = 1'b1;
        @(negedge Clock_1us);

        for (int i = 0; i < 5; i++) begin
            txn(vecs[i].addr, vecs[i].data, vecs[i].both);
            check("vec_cursor", int'(cursor), vecs[i].exp_cursor);
            check("vec_proto", int'(proto_err), int'(vecs[i].exp_proto));
            read_cell(vecs[i].exp_cell, v);
            check("vec_cell", v, vecs[i].data);
        end

        // Reset clears error and cursor but keeps panel contents.
        do_reset();
        check("rst2_proto", int'(proto_err), 0);
        check("rst2_cursor", int'(cursor), 0);
        read_cell(5, v);
        check("mem_kept_over_reset", v, 'h41);

        // Data strobe while idle: flagged, otherwise ignored.
        pulse(1'b0, 1'b1);
        proto_m = 1'b1;
        check("idle_data_proto", int'(proto_err), 1);
        check("idle_data_cursor", int'(cursor), 0);
        read_cell(0, v);
        check("idle_data_mem", v, mem_m[0]);

        // Reset while an update waits for its data strobe drops it.
        do_reset();
        txn(30, 'h11, 1'b0);
        host_put(30, 'h99);
        if (model_need_addr(30)) pulse(1'b1, 1'b0);
        check("pend_data_addr_acq", int'(ms6205_addr_acq), 0);
        check("pend_data_data_acq", int'(ms6205_data_acq), 1);
        Rst_n = 1'b0;
        #1;
        check("rst_pend_ready", int'(host_ready), 1);
        check("rst_pend_addr_acq", int'(ms6205_addr_acq), 0);
        check("rst_pend_data_acq", int'(ms6205_data_acq), 0);
        @(negedge Clock_1us);
        Rst_n = 1'b1;
        @(negedge Clock_1us);
        cursor_m = 0;
        proto_m  = 1'b0;
        read_cell(30, v);
        check("rst_pend_mem_kept", v, 'h11);

        // Data strobe before the address strobe is flagged and does not write.
        host_put(50, 'h22);
        check("early_data_addr_acq", int'(ms6205_addr_acq), 1);
        pulse(1'b0, 1'b1);
        check("early_data_proto", int'(proto_err), 1);
        check("early_data_still_pend", int'(ms6205_addr_acq), 1);
        pulse(1'b1, 1'b0);
        check("early_data_cursor", int'(cursor), 50);
        pulse(1'b0, 1'b1);
        mem_m[50] = 'h22;
        cursor_m  = 51;
        proto_m   = 1'b1;
        check("early_data_cursor_done", int'(cursor), 51);
        read_cell(50, v);
        check("early_data_mem", v, 'h22);

        do_reset();
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                pulse(1'b0, 1'b1);
                proto_m = 1'b1;
                check("rnd_idle_proto", int'(proto_err), 1);
                check("rnd_idle_cursor", int'(cursor), cursor_m);
            end
            if ($urandom_range(0, 3) == 0) a = (cursor_m + 0) % DEPTH;
            else a = $urandom_range(0, 175);
            d = $urandom_range(0, 255);
            txn(a, d, 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
